// File: rtl/aclock_ui_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aclock_ui_ctrl
// Description : Button-driven time/alarm editor, load strobes, alarm enable
//               and snooze/dismiss scheduler for the aclock core.
// Revision    : 1.0 - initial release
// ============================================================================
module aclock_ui_ctrl #(
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned MAX_SNOOZE   = 3,
    parameter int unsigned EDIT_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SEC_TICK,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    input  logic       BTN_SNOOZE,
    input  logic       Alarm,
    output logic [1:0] Hpoz2,
    output logic [3:0] Hpoz1,
    output logic [3:0] Mpoz2,
    output logic [3:0] Mpoz1,
    output logic       LDT,
    output logic       LDA,
    output logic       STOP_ALARM,
    output logic       ALARM_ON,
    output logic       RING,
    output logic [2:0] EDIT
);

    localparam int c_SNZ_W  = ($clog2(SNOOZE_SEC + 1)   > 0) ? $clog2(SNOOZE_SEC + 1)   : 1;
    localparam int c_CNT_W  = ($clog2(MAX_SNOOZE + 1)   > 0) ? $clog2(MAX_SNOOZE + 1)   : 1;
    localparam int c_IDLE_W = ($clog2(EDIT_TIMEOUT + 1) > 0) ? $clog2(EDIT_TIMEOUT + 1) : 1;

    localparam logic [c_SNZ_W-1:0]  c_SNZ_LOAD  = c_SNZ_W'(SNOOZE_SEC);
    localparam logic [c_SNZ_W-1:0]  c_SNZ_ONE   = c_SNZ_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(MAX_SNOOZE);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(EDIT_TIMEOUT - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

    localparam logic [2:0] c_ST_RUN    = 3'd0;
    localparam logic [2:0] c_ST_T_HR   = 3'd1;
    localparam logic [2:0] c_ST_T_MIN  = 3'd2;
    localparam logic [2:0] c_ST_T_LOAD = 3'd3;
    localparam logic [2:0] c_ST_A_HR   = 3'd4;
    localparam logic [2:0] c_ST_A_MIN  = 3'd5;
    localparam logic [2:0] c_ST_A_LOAD = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [1:0]          r_h2;
    logic [3:0]          r_h1;
    logic [3:0]          r_m2;
    logic [3:0]          r_m1;
    logic [c_IDLE_W-1:0] r_idle;
    logic [c_SNZ_W-1:0]  r_snz_cnt;
    logic                r_snz_pend;
    logic [c_CNT_W-1:0]  r_snz_num;
    logic                r_rering;
    logic                r_stop;
    logic                r_alarm_on;

    logic       w_mode;
    logic       w_inc;
    logic       w_snz;
    logic       w_any;
    logic       w_ring;
    logic       w_run;
    logic       w_hr_st;
    logic       w_min_st;
    logic       w_edit_st;
    logic       w_timeout;
    logic       w_enter_hr;
    logic       w_snooze;
    logic       w_dismiss;
    logic       w_alarm_off;
    logic       w_ldt;
    logic       w_lda;
    logic [1:0] w_h2_inc;
    logic [3:0] w_h1_inc;
    logic [3:0] w_m2_inc;
    logic [3:0] w_m1_inc;

    // Fixed button priority: MODE over INC over SNOOZE.
    assign w_mode = BTN_MODE;
    assign w_inc  = BTN_INC & ~BTN_MODE;
    assign w_snz  = BTN_SNOOZE & ~BTN_MODE & ~BTN_INC;
    assign w_any  = BTN_MODE | BTN_INC | BTN_SNOOZE;

    assign w_ring    = Alarm | r_rering;
    assign w_run     = (r_state == c_ST_RUN);
    assign w_hr_st   = (r_state == c_ST_T_HR)  || (r_state == c_ST_A_HR);
    assign w_min_st  = (r_state == c_ST_T_MIN) || (r_state == c_ST_A_MIN);
    assign w_edit_st = w_hr_st || w_min_st;
    assign w_timeout = w_edit_st && SEC_TICK && !w_any && (r_idle == c_IDLE_LAST);

    assign w_snooze    = w_run && w_ring && w_snz && (r_snz_num < c_CNT_MAX);
    assign w_dismiss   = w_run && w_ring && (w_mode || (w_snz && (r_snz_num >= c_CNT_MAX)));
    assign w_alarm_off = w_run && w_inc && r_alarm_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A MODE press that dismisses a ringing alarm never opens the editor.
    always_comb begin
        w_state_nxt = r_state;
        w_ldt       = 1'b0;
        w_lda       = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_mode && !w_ring) w_state_nxt = c_ST_T_HR;
            end
            c_ST_T_HR: begin
                if (w_mode)         w_state_nxt = c_ST_T_MIN;
                else if (w_timeout) w_state_nxt = c_ST_RUN;
            end
            c_ST_T_MIN: begin
                if (w_mode)         w_state_nxt = c_ST_T_LOAD;
                else if (w_timeout) w_state_nxt = c_ST_RUN;
            end
            c_ST_T_LOAD: begin
                w_ldt       = 1'b1;
                w_state_nxt = c_ST_A_HR;
            end
            c_ST_A_HR: begin
                if (w_mode)         w_state_nxt = c_ST_A_MIN;
                else if (w_timeout) w_state_nxt = c_ST_RUN;
            end
            c_ST_A_MIN: begin
                if (w_mode)         w_state_nxt = c_ST_A_LOAD;
                else if (w_timeout) w_state_nxt = c_ST_RUN;
            end
            c_ST_A_LOAD: begin
                w_lda       = 1'b1;
                w_state_nxt = c_ST_RUN;
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    assign w_enter_hr = (w_state_nxt != r_state) &&
                        ((w_state_nxt == c_ST_T_HR) || (w_state_nxt == c_ST_A_HR));

    // Hours: 23 wraps before the units carry is considered.
    always_comb begin
        w_h2_inc = r_h2;
        w_h1_inc = r_h1 + 4'd1;
        if ((r_h2 == 2'd2) && (r_h1 == 4'd3)) begin
            w_h2_inc = 2'd0;
            w_h1_inc = 4'd0;
        end else if (r_h1 == 4'd9) begin
            w_h2_inc = r_h2 + 2'd1;
            w_h1_inc = 4'd0;
        end
    end

    always_comb begin
        w_m2_inc = r_m2;
        w_m1_inc = r_m1 + 4'd1;
        if ((r_m2 == 4'd5) && (r_m1 == 4'd9)) begin
            w_m2_inc = 4'd0;
            w_m1_inc = 4'd0;
        end else if (r_m1 == 4'd9) begin
            w_m2_inc = r_m2 + 4'd1;
            w_m1_inc = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_enter_hr) begin
            r_h2 <= 2'd0;
            r_h1 <= 4'd0;
            r_m2 <= 4'd0;
            r_m1 <= 4'd0;
        end else if (w_inc && w_hr_st) begin
            r_h2 <= w_h2_inc;
            r_h1 <= w_h1_inc;
        end else if (w_inc && w_min_st) begin
            r_m2 <= w_m2_inc;
            r_m1 <= w_m1_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_edit_st || w_any || w_timeout) begin
            r_idle <= '0;
        end else if (SEC_TICK) begin
            r_idle <= r_idle + c_IDLE_ONE;
        end
    end

    // Button actions take precedence over a coincident countdown tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stop     <= 1'b0;
            r_alarm_on <= 1'b0;
            r_snz_cnt  <= '0;
            r_snz_pend <= 1'b0;
            r_snz_num  <= '0;
            r_rering   <= 1'b0;
        end else begin
            r_stop <= w_snooze | w_dismiss;
            if (w_run && w_inc) r_alarm_on <= ~r_alarm_on;
            if (w_dismiss || w_alarm_off) begin
                r_snz_cnt  <= '0;
                r_snz_pend <= 1'b0;
                r_snz_num  <= '0;
                r_rering   <= 1'b0;
            end else if (w_snooze) begin
                r_snz_cnt  <= c_SNZ_LOAD;
                r_snz_pend <= 1'b1;
                r_snz_num  <= r_snz_num + c_CNT_ONE;
                r_rering   <= 1'b0;
            end else if (r_snz_pend && SEC_TICK) begin
                r_snz_cnt <= r_snz_cnt - c_SNZ_ONE;
                if (r_snz_cnt == c_SNZ_ONE) begin
                    r_snz_pend <= 1'b0;
                    r_rering   <= 1'b1;
                end
            end
        end
    end

    assign Hpoz2      = r_h2;
    assign Hpoz1      = r_h1;
    assign Mpoz2      = r_m2;
    assign Mpoz1      = r_m1;
    assign LDT        = w_ldt;
    assign LDA        = w_lda;
    assign STOP_ALARM = r_stop;
    assign ALARM_ON   = r_alarm_on;
    assign RING       = w_ring;
    assign EDIT       = r_state;

endmodule
`default_nettype wire

// File: doc/aclock_ui_ctrl.md
# aclock_ui_ctrl

User-interface sequencer for the 24-hour alarm clock core `aclock`. It turns three debounced push-button pulses into BCD time/alarm values, issues the one-cycle `LDT`/`LDA` load strobes, and owns the alarm enable. It also schedules snooze/dismiss by driving `STOP_ALARM` and producing a re-ring output. It sits between the button conditioning logic and `aclock`, driving that core's load inputs directly.

## Interface
- `SNOOZE_SEC`, default 300: seconds from a snooze press until re-ring.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; further snooze presses behave as dismiss.
- `EDIT_TIMEOUT`, default 30: idle seconds in any edit state before abandoning the edit.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `SEC_TICK` in 1: one-cycle pulse, once per second.
- `BTN_MODE` in 1: one-cycle pulse, already debounced.
- `BTN_INC` in 1: one-cycle pulse, already debounced.
- `BTN_SNOOZE` in 1: one-cycle pulse, already debounced.
- `Alarm` in 1: alarm flag from `aclock`.
- `Hpoz2` out 2: hour tens, BCD, to `aclock`.
- `Hpoz1` out 4: hour units, BCD.
- `Mpoz2` out 4: minute tens, BCD.
- `Mpoz1` out 4: minute units, BCD.
- `LDT` out 1: one-cycle time-load strobe.
- `LDA` out 1: one-cycle alarm-load strobe.
- `STOP_ALARM` out 1: one-cycle stop strobe to `aclock`.
- `ALARM_ON` out 1: alarm enable level to `aclock`.
- `RING` out 1: buzzer drive, equal to `Alarm | rering`.
- `EDIT` out 3: current FSM state code, for display blanking.

## Operation
- FSM states and codes: RUN(0), T_HR(1), T_MIN(2), T_LOAD(3), A_HR(4), A_MIN(5), A_LOAD(6).
- Mode sequence: `BTN_MODE` advances RUN→T_HR→T_MIN→T_LOAD. T_LOAD lasts 1 cycle, then A_HR. `BTN_MODE` then advances A_HR→A_MIN→A_LOAD. A_LOAD lasts 1 cycle, then RUN.
- Entering T_HR or A_HR clears the edit register to 00:00.
- Editing: `BTN_INC` in an *_HR state increments hours 00..23; 23 wraps to 00 with minutes unchanged. `BTN_INC` in an *_MIN state increments minutes 00..59; 59 wraps to 00 with no carry into hours.
- BCD arithmetic: units 9→0 with tens+1. Hours 23→00 is checked before the units carry. Digit outputs never hold a non-BCD value or an out-of-range time.
- Loads: `LDT`=1 only in T_LOAD; `LDA`=1 only in A_LOAD. `Hpoz2`..`Mpoz1` hold the edit register at all times, so they are valid during and after each strobe.
- Alarm enable: `BTN_INC` in RUN toggles `ALARM_ON`. Clearing `ALARM_ON` also cancels any pending snooze and `rering`.
- Edit timeout: in T_HR, T_MIN, A_HR or A_MIN, an idle counter counts `SEC_TICK`s and clears on any button. When it reaches `EDIT_TIMEOUT`, the FSM returns to RUN with no load strobe.
- Snooze scheduler, active in RUN only, while `RING`=1:
  - Snooze: `BTN_SNOOZE` with snooze count < `MAX_SNOOZE` pulses `STOP_ALARM`, clears `rering`, loads the snooze counter with `SNOOZE_SEC`, and increments the snooze count.
  - Re-ring: the snooze counter decrements on `SEC_TICK`. On reaching 0 it sets `rering`=1.
  - Dismiss: `BTN_MODE`, or `BTN_SNOOZE` with count = `MAX_SNOOZE`, pulses `STOP_ALARM`, clears `rering`, the snooze counter and the count, and keeps the FSM in RUN. This press does not enter T_HR.
- Simultaneous buttons: priority is MODE > INC > SNOOZE; lower-priority pulses in the same cycle are ignored.
- `Alarm` rising while a snooze is pending: `RING`=1 immediately, and the snooze counter keeps running.

## Timing
- Reset values: FSM=RUN, edit register 00:00, `LDT`=`LDA`=`STOP_ALARM`=0, `ALARM_ON`=0, `RING`=0 apart from a live `Alarm`, all counters and the snooze count = 0.
- Reset mid-edit discards the edit with no load strobe. Reset during snooze cancels the snooze.
- Button to state change: 1 cycle, registered.
- Button to `STOP_ALARM`: asserted in the cycle after the button pulse, for exactly 1 cycle.
- `BTN_MODE` in T_MIN gives `LDT`=1 in the next cycle; `BTN_MODE` in A_MIN gives `LDA`=1 in the next cycle.
- `LDT` and `LDA` are never both high. Neither is ever high for 2 consecutive cycles.
- `SEC_TICK` and a button in the same cycle: the button is processed, and the idle counter is cleared rather than incremented.
- `rering` is registered: it rises 1 cycle after the `SEC_TICK` that brings the snooze counter to 0.

## Test plan
- Set time: reset, then MODE, 14×INC, MODE, 37×INC, MODE. Require `LDT` for 1 cycle with digits 1,4,3,7, and no `LDA`.
- Hour and minute wrap: in T_HR press INC 24×, require 00. In T_MIN press INC 60×, require minutes 00 with hours unchanged. Also sample a BCD carry, e.g. 09→10.
- Alarm load and enable: complete the alarm edit to 00:05 and require `LDA`=1 with `Hpoz2`=0, `Hpoz1`=0, `Mpoz2`=0, `Mpoz1`=5. Then INC in RUN and require `ALARM_ON`=1.
- Snooze: drive `Alarm`=1, press SNOOZE. Require a 1-cycle `STOP_ALARM`, `RING`=0 once `Alarm` drops, then `RING`=1 exactly `SNOOZE_SEC` ticks later. The 4th snooze press (with `MAX_SNOOZE`=3) must dismiss with no re-ring.
- Edit timeout: enter A_MIN and apply `EDIT_TIMEOUT` ticks with no buttons. Require return to RUN with no `LDA`. Verify an INC at tick 29 restarts the count.
- Priority and reset: MODE+INC in the same cycle in RUN → T_HR with `ALARM_ON` unchanged. Reset asserted in T_MIN → RUN, digits 00:00, no `LDT`.
